// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART bridge TX input between N_PORTS AXI-Stream requesters.
// A grant lasts until TLAST or MAX_BURST beats; winning beats pass through a 1-deep output register.
module axis_uart_tx_arbiter #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned N_BYTES   = 32,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned DW       = N_BYTES * 8,
  localparam int unsigned IdW      = $clog2(N_PORTS),
  localparam int unsigned CntW     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_PORTS*DW-1:0]   S_AXIS_TDATA,
  input  logic [N_PORTS-1:0]      S_AXIS_TVALID,
  input  logic [N_PORTS-1:0]      S_AXIS_TLAST,
  output logic [N_PORTS-1:0]      S_AXIS_TREADY,
  output logic [DW-1:0]           M_AXIS_TDATA,
  output logic [IdW-1:0]          M_AXIS_TID,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic [DW-1:0]   out_data_q;
  logic [IdW-1:0]  out_id_q;
  logic            out_last_q;
  logic            out_valid_q;

  logic [DW-1:0]   sel_data;
  logic            sel_last;
  logic            sel_valid;
  logic            out_free;
  logic            accept;
  logic [IdW-1:0]  pick;
  logic [IdW-1:0]  cand;
  logic            found;

  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] v);
    return (v == IdW'(N_PORTS - 1)) ? '0 : v + IdW'(1);
  endfunction

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = rr_ptr_q;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && S_AXIS_TVALID[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  assign out_free = !out_valid_q || M_AXIS_TREADY;

  always_comb begin
    sel_data      = '0;
    sel_last      = 1'b0;
    sel_valid     = 1'b0;
    S_AXIS_TREADY = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant_q == IdW'(i)) begin
        sel_data         = S_AXIS_TDATA[i*DW +: DW];
        sel_last         = S_AXIS_TLAST[i];
        sel_valid        = S_AXIS_TVALID[i];
        S_AXIS_TREADY[i] = (state_q == StGrant) && out_free;
      end
    end
  end

  assign accept = (state_q == StGrant) && sel_valid && out_free;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|S_AXIS_TVALID) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (sel_last || beat_cnt_q == CntW'(MAX_BURST - 1)) begin
            state_d  = StIdle;
            rr_ptr_d = wrap_inc(grant_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Accepting and draining in one cycle reloads the register, keeping full throughput.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_data_q  <= sel_data;
      out_id_q    <= grant_q;
      out_last_q  <= sel_last;
      out_valid_q <= 1'b1;
    end else if (M_AXIS_TREADY && out_valid_q) begin
      out_valid_q <= 1'b0;
    end
  end

  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TID    = out_id_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign M_AXIS_TVALID = out_valid_q;

endmodule
